// File: rtl/sreg_seq.sv
// rtl/sreg_seq.sv - job-level sequencer expanding cfg/readout/readback jobs into sreg_ctrl opcodes
// Fetches config words from a sync RAM, streams readout words with backpressure, aborts stuck commands.
module sreg_seq #(
  parameter int NPIX_MAX = 64,
  parameter int DW       = 42,
  parameter int TMO      = 255,
  localparam int NW      = $clog2(NPIX_MAX) + 1,
  localparam int AW      = $clog2(NPIX_MAX),
  localparam int TW      = $clog2(TMO + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [1:0]    job_op,
  input  logic [NW-1:0] job_npix,
  input  logic          job_pclk,
  output logic          cfg_req,
  output logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          cmd_valid,
  output logic [2:0]    cmd,
  output logic [DW-1:0] cmd_data,
  input  logic          cmd_ready,
  input  logic [DW-1:0] sreg_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [1:0] OP_CFG  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_SREG = 2'b10;

  localparam logic [2:0] C_PIX_WRITE    = 3'b000;
  localparam logic [2:0] C_PIX_READ     = 3'b001;
  localparam logic [2:0] C_PIX_READ_END = 3'b010;
  localparam logic [2:0] C_PCLK0        = 3'b011;
  localparam logic [2:0] C_PCLK1        = 3'b100;
  localparam logic [2:0] C_SREG_READ    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_LOW, S_WAIT_DONE, S_PUSH, S_TAIL, S_FIN
  } state_t;

  state_t          state, state_n;
  logic [1:0]      op_r;
  logic [NW-1:0]   npix_r;
  logic            pclk_r;
  logic [NW-1:0]   idx;
  logic            fetch_ph;
  logic            tail_r;
  logic [TW-1:0]   tmo_cnt;
  logic [2:0]      cmd_r;
  logic [DW-1:0]   cmd_data_r;
  logic [DW-1:0]   rd_data_r;
  logic [1:0]      err_code_r;

  logic job_ill, last, tmo_hit, complete, tmo_abort;

  assign job_ill  = (job_op == 2'b11) ||
                    ((job_op != OP_SREG) && ((job_npix == '0) || (job_npix > NW'(NPIX_MAX))));
  assign last     = (idx == npix_r - NW'(1));
  assign tmo_hit  = (tmo_cnt >= TW'(TMO - 1));
  assign complete = (state == S_WAIT_DONE) && cmd_ready;
  // Completion takes priority over a timeout landing in the same cycle.
  assign tmo_abort = tmo_hit && ((state == S_WAIT_LOW) || ((state == S_WAIT_DONE) && !cmd_ready));

  assign cfg_addr = idx[AW-1:0];
  assign cmd      = cmd_r;
  assign cmd_data = cmd_data_r;
  assign rd_data  = rd_data_r;
  assign err_code = err_code_r;

  always_comb begin
    state_n   = state;
    job_ready = 1'b0;
    cfg_req   = 1'b0;
    cmd_valid = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) begin
          if (job_ill)               state_n = S_FIN;
          else if (job_op == OP_CFG) state_n = S_FETCH;
          else                       state_n = S_ISSUE;
        end
      end
      S_FETCH: begin
        cfg_req = !fetch_ph;
        if (fetch_ph) state_n = S_ISSUE;
      end
      S_ISSUE, S_TAIL: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_n = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (tmo_abort)       state_n = S_FIN;
        else if (!cmd_ready) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (complete) begin
          if (tail_r)                state_n = S_FIN;
          else if (op_r == OP_CFG)   state_n = last ? S_TAIL : S_FETCH;
          else                       state_n = S_PUSH;
        end else if (tmo_abort) begin
          state_n = S_FIN;
        end
      end
      S_PUSH: begin
        rd_valid = 1'b1;
        rd_last  = last;
        if (rd_ready) begin
          if (!last)                state_n = S_ISSUE;
          else if (op_r == OP_READ) state_n = S_TAIL;
          else                      state_n = S_FIN;
        end
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        err     = (err_code_r != 2'b00);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_r       <= '0;
      npix_r     <= '0;
      pclk_r     <= 1'b0;
      idx        <= '0;
      fetch_ph   <= 1'b0;
      tail_r     <= 1'b0;
      tmo_cnt    <= '0;
      cmd_r      <= '0;
      cmd_data_r <= '0;
      rd_data_r  <= '0;
      err_code_r <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            op_r       <= job_op;
            npix_r     <= (job_op == OP_SREG) ? NW'(1) : job_npix;
            pclk_r     <= job_pclk;
            idx        <= '0;
            fetch_ph   <= 1'b0;
            tail_r     <= 1'b0;
            err_code_r <= job_ill ? 2'b01 : 2'b00;
            if (!job_ill && (job_op != OP_CFG)) begin
              cmd_r      <= (job_op == OP_SREG) ? C_SREG_READ : C_PIX_READ;
              cmd_data_r <= '0;
            end
          end
        end
        S_FETCH: begin
          fetch_ph <= !fetch_ph;
          if (fetch_ph) begin
            cmd_r      <= C_PIX_WRITE;
            cmd_data_r <= cfg_data;
          end
        end
        S_ISSUE, S_TAIL: begin
          if (cmd_ready) tmo_cnt <= '0;
        end
        S_WAIT_LOW, S_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (complete) begin
            if (!tail_r) begin
              if (op_r == OP_CFG) begin
                if (last) begin
                  tail_r     <= 1'b1;
                  cmd_r      <= pclk_r ? C_PCLK1 : C_PCLK0;
                  cmd_data_r <= '0;
                end else begin
                  idx <= idx + NW'(1);
                end
              end else begin
                rd_data_r <= sreg_data;
              end
            end
          end else if (tmo_abort) begin
            err_code_r <= 2'b10;
          end
        end
        S_PUSH: begin
          if (rd_ready) begin
            if (!last) begin
              idx <= idx + NW'(1);
            end else if (op_r == OP_READ) begin
              tail_r     <= 1'b1;
              cmd_r      <= C_PIX_READ_END;
              cmd_data_r <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_seq.sv
// tb/tb_sreg_seq.sv - randomized self-checking bench for sreg_seq with job-level reference model
module tb_sreg_seq;
  localparam int NPIX_MAX = 64;
  localparam int DW       = 42;
  localparam int TMO      = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1:0]    job_op = '0;
  logic [6:0]    job_npix = '0;
  logic          job_pclk = 1'b0;
  logic          cfg_req;
  logic [5:0]    cfg_addr;
  logic [DW-1:0] cfg_data = '0;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready = 1'b1;
  logic [DW-1:0] sreg_data = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready = 1'b0;
  logic          busy, done, err;
  logic [1:0]    err_code;

  sreg_seq #(.NPIX_MAX(NPIX_MAX), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_op(job_op), .job_npix(job_npix), .job_pclk(job_pclk),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .sreg_data(sreg_data), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_ready(rd_ready), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Environment state
  logic [DW-1:0] ram [NPIX_MAX];
  int            rd_mode = 1;      // 0 hold low, 1 always ready, 2 random
  int            rsp_fix = 0;      // nonzero: fixed busy time of the sreg_ctrl model
  bit            rsp_stuck = 0;
  bit            rsp_release = 0;
  bit            rsp_busy = 0;
  int            rsp_cnt = 0;
  logic [DW-1:0] force_q [$];

  // Negedge samples consumed by the posedge driver
  bit            req_s = 0, hs_cmd_s = 0;
  logic [5:0]    addr_s = '0;
  logic [2:0]    cmd_s = '0;
  logic [DW-1:0] cmd_data_s = '0;

  // Reference model of the current job
  logic [2:0]    exp_op [$];
  logic [DW-1:0] exp_dat [$];
  logic [DW-1:0] exp_rd [$];
  logic [1:0]    exp_code = '0;
  bit            exp_ill = 0;
  bit            job_active = 0;
  int            rd_left = 0;
  int            cyc = 0, acc_cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [1:0]    last_code = '0;
  logic [2:0]    cur_cmd = '0;
  logic [DW-1:0] cur_dat = '0;
  bit            prev_done = 0, prev_stall = 0;
  logic [DW-1:0] prev_rd_data = '0;
  logic [2:0]    log_op [$];
  logic [DW-1:0] log_dat [$];
  logic [DW-1:0] rd_log [$];
  bit            last_log [$];

  // sreg_ctrl model, config RAM and sink
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      rsp_busy  = 0;
      cmd_ready = 1'b1;
    end else if (hs_cmd_s) begin
      rsp_busy  = 1;
      cmd_ready = 1'b0;
      rsp_cnt   = (rsp_fix != 0) ? rsp_fix : int'($urandom_range(1, 4));
      if (force_q.size() > 0) sreg_data = force_q.pop_front();
      else sreg_data = DW'({$urandom, $urandom});
      if (cmd_s == 3'b001 || cmd_s == 3'b111) exp_rd.push_back(sreg_data);
      log_op.push_back(cmd_s);
      log_dat.push_back(cmd_data_s);
    end else if (rsp_busy) begin
      if (rsp_release) begin
        rsp_busy  = 0;
        cmd_ready = 1'b1;
      end else if (!rsp_stuck) begin
        rsp_cnt--;
        if (rsp_cnt <= 0) begin
          rsp_busy  = 0;
          cmd_ready = 1'b1;
        end
      end
    end
    cfg_data = req_s ? ram[addr_s] : DW'({$urandom, $urandom});
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      job_active = 0; prev_done = 0; prev_stall = 0;
      req_s = 0; hs_cmd_s = 0;
      exp_op.delete(); exp_dat.delete(); exp_rd.delete();
    end else begin
      cyc++;
      chk("busy_vs_ready", busy & job_ready, 0);
      if (prev_done) chk("ready_after_done", job_ready, 1);
      if (prev_stall) begin
        chk("rd_valid_held", rd_valid, 1);
        chk("rd_data_held", rd_data, prev_rd_data);
      end
      if (rd_valid) chk("no_cmd_during_push", cmd_valid, 0);
      if (rsp_busy && job_active) begin
        chk("cmd_stable", cmd, cur_cmd);
        chk("cmd_data_stable", cmd_data, cur_dat);
        chk("cmd_valid_dropped", cmd_valid, 0);
      end
      if (job_active && !done && cyc > acc_cyc) chk("busy_in_job", busy, 1);
      if (cmd_valid && cmd_ready) begin
        hs_cyc = cyc; cur_cmd = cmd; cur_dat = cmd_data;
        if (exp_op.size() == 0) chk("unexpected_cmd", {cmd_data, cmd}, 0);
        else begin
          chk("cmd_op", cmd, exp_op.pop_front());
          chk("cmd_data", cmd_data, exp_dat.pop_front());
        end
      end
      if (rd_valid && rd_ready) begin
        rd_log.push_back(rd_data);
        last_log.push_back(rd_last);
        if (exp_rd.size() == 0) chk("unexpected_rd", {1'b1, rd_data}, 0);
        else chk("rd_data", rd_data, exp_rd.pop_front());
        chk("rd_last", rd_last, rd_left == 1);
        rd_left--;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; last_code = err_code;
        chk("done_in_job", job_active, 1);
        chk("err_code", err_code, exp_code);
        chk("err", err, exp_code != 0);
        if (exp_ill) chk("illegal_latency", cyc - acc_cyc, 1);
        if (exp_code == 0) chk("job_drained", exp_op.size() + exp_rd.size() + rd_left, 0);
        job_active = 0;
        exp_op.delete(); exp_dat.delete(); exp_rd.delete();
      end
      if (job_valid && job_ready) begin
        exp_ill = (job_op == 2'b11) ||
                  (job_op != 2'b10 && (job_npix == 0 || job_npix > NPIX_MAX));
        exp_code = exp_ill ? 2'b01 : (rsp_stuck ? 2'b10 : 2'b00);
        exp_op.delete(); exp_dat.delete(); exp_rd.delete();
        job_active = 1; acc_cyc = cyc; rd_left = 0;
        if (!exp_ill) begin
          case (job_op)
            2'b00: begin
              for (int i = 0; i < int'(job_npix); i++) begin
                exp_op.push_back(3'b000); exp_dat.push_back(ram[i]);
              end
              exp_op.push_back(job_pclk ? 3'b100 : 3'b011); exp_dat.push_back('0);
            end
            2'b01: begin
              for (int i = 0; i < int'(job_npix); i++) begin
                exp_op.push_back(3'b001); exp_dat.push_back('0);
              end
              exp_op.push_back(3'b010); exp_dat.push_back('0);
              rd_left = int'(job_npix);
            end
            default: begin
              exp_op.push_back(3'b111); exp_dat.push_back('0);
              rd_left = 1;
            end
          endcase
        end
      end
      prev_done    = done;
      prev_stall   = rd_valid && !rd_ready;
      prev_rd_data = rd_data;
      req_s        = cfg_req;
      addr_s       = cfg_addr;
      hs_cmd_s     = cmd_valid && cmd_ready;
      cmd_s        = cmd;
      cmd_data_s   = cmd_data;
    end
  end

  task automatic submit(input logic [1:0] op, input logic [6:0] n, input logic pc);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!job_ready && k < 5000) begin @(posedge clk); #1; k++; end
    if (!job_ready) chk("job_ready_wait", 0, 1);
    job_op = op; job_npix = n; job_pclk = pc; job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_op = 2'($urandom); job_npix = 7'($urandom); job_pclk = 1'($urandom);
  endtask

  task automatic run_job(input logic [1:0] op, input logic [6:0] n, input logic pc, input int lim);
    int s, k;
    s = done_cnt; k = 0;
    submit(op, n, pc);
    while (done_cnt == s && k < lim) begin @(negedge clk); k++; end
    if (done_cnt == s) chk("done_wait", 0, 1);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    log_op.delete(); log_dat.delete(); rd_log.delete(); last_log.delete();
  endtask

  initial begin
    int k;
    for (int i = 0; i < NPIX_MAX; i++) ram[i] = 42'h3_0000_0000 + 42'(i);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_outputs", {cfg_req, cmd_valid, rd_valid, rd_last, busy, done, err}, 0);
    chk("rst_values", {err_code, cmd, cmd_data, rd_data}, 0);
    rst_n = 1'b1;

    // cfg write npix=3 pclk=1
    clear_logs();
    run_job(2'b00, 7'd3, 1'b1, 500);
    chk("t1_ncmd", log_op.size(), 4);
    if (log_op.size() == 4) begin
      chk("t1_op0", {log_op[0], log_dat[0]}, {3'b000, 42'h3_0000_0000});
      chk("t1_op1", {log_op[1], log_dat[1]}, {3'b000, 42'h3_0000_0001});
      chk("t1_op2", {log_op[2], log_dat[2]}, {3'b000, 42'h3_0000_0002});
      chk("t1_tail", {log_op[3], log_dat[3]}, {3'b100, 42'h0});
    end
    chk("t1_code", last_code, 0);

    // readout npix=2
    clear_logs();
    force_q.push_back(42'hA5); force_q.push_back(42'h5A);
    run_job(2'b01, 7'd2, 1'b0, 500);
    chk("t2_nrd", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("t2_w0", {last_log[0], rd_log[0]}, {1'b0, 42'hA5});
      chk("t2_w1", {last_log[1], rd_log[1]}, {1'b1, 42'h5A});
    end
    chk("t2_ncmd", log_op.size(), 3);
    if (log_op.size() == 3) chk("t2_tail", log_op[2], 3'b010);

    // readout with 20-cycle stall on word 0
    clear_logs();
    rd_mode = 0;
    force_q.push_back(42'h11); force_q.push_back(42'h22);
    submit(2'b01, 7'd2, 1'b0);
    k = 0;
    while (!rd_valid && k < 200) begin @(negedge clk); k++; end
    chk("t3_rd_valid", rd_valid, 1);
    repeat (20) @(negedge clk);
    chk("t3_stalled", {rd_valid, cmd_valid, rd_data}, {1'b1, 1'b0, 42'h11});
    chk("t3_ncmd", log_op.size(), 1);
    rd_mode = 1;
    k = 0;
    while (job_active && k < 500) begin @(negedge clk); k++; end
    chk("t3_finished", job_active, 0);
    chk("t3_nrd", rd_log.size(), 2);
    if (rd_log.size() == 2) chk("t3_order", {rd_log[0], rd_log[1]}, {42'h11, 42'h22});

    // illegal jobs
    clear_logs();
    run_job(2'b11, 7'd5, 1'b0, 20);
    chk("t4_op11", last_code, 2'b01);
    run_job(2'b00, 7'd0, 1'b0, 20);
    chk("t4_npix0", last_code, 2'b01);
    run_job(2'b01, 7'd65, 1'b0, 20);
    chk("t4_npix65", last_code, 2'b01);
    chk("t4_nocmd", log_op.size(), 0);

    // stuck sreg_ctrl -> timeout abort
    rsp_stuck = 1;
    run_job(2'b01, 7'd1, 1'b0, 1000);
    chk("t5_code", last_code, 2'b10);
    chk("t5_tmo_window", (done_cyc - hs_cyc >= TMO) && (done_cyc - hs_cyc <= TMO + 2), 1);
    rsp_release = 1;
    repeat (3) @(posedge clk);
    rsp_release = 0; rsp_stuck = 0;
    clear_logs();
    run_job(2'b10, 7'd0, 1'b0, 500);
    chk("t5_recover", {last_code, 32'(rd_log.size())}, {2'b00, 32'd1});

    // reset during WAIT_DONE of a cfg write
    rsp_fix = 30;
    submit(2'b00, 7'd2, 1'b0);
    k = 0;
    while (!rsp_busy && k < 100) begin @(negedge clk); k++; end
    chk("t6_in_wait", rsp_busy, 1);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ready", job_ready, 1);
    chk("t6_outputs", {cfg_req, cmd_valid, rd_valid, rd_last, busy, done, err}, 0);
    chk("t6_values", {err_code, cmd, cmd_data, rd_data}, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    rsp_fix = 0;
    clear_logs();
    run_job(2'b00, 7'd2, 1'b0, 500);
    chk("t6_fresh", {last_code, 32'(log_op.size())}, {2'b00, 32'd3});

    // randomized jobs
    rd_mode = 2;
    for (int j = 0; j < 40; j++) begin
      logic [1:0] op;
      logic [6:0] n;
      for (int i = 0; i < NPIX_MAX; i++) ram[i] = DW'({$urandom, $urandom});
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      n  = ($urandom_range(0, 19) == 0) ? 7'd64 : 7'($urandom_range(1, 6));
      if ($urandom_range(0, 19) == 0) n = 7'($urandom_range(65, 127));
      run_job(op, n, 1'($urandom), 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
